ln_series: RTL and testbench

LN_SERIES -- requirements
Module: ln_series

---
 rtl/ln_series.sv | 144 ++++++++++++++
 tb/tb_ln_series.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ln_series.sv
// Natural log of an unsigned Q8.8 operand near 1.0, by summing the
// alternating series ln(1+u) = u - u^2/2 + u^3/3 - ... until a term is small.
module ln_series #(
  parameter int MAX_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [7:0]  eps,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        range_err,
  output logic [3:0]  terms
);

  typedef enum logic [2:0] {IDLE, LOAD, TERM, ACC, DONE} state_t;

  state_t             state;
  logic [15:0]        x_reg;
  logic [7:0]         eps_reg;
  logic signed [15:0] u;
  logic signed [15:0] pow;
  logic signed [15:0] acc;
  logic signed [15:0] term;
  logic [3:0]         k;

  logic               in_range;
  logic [15:0]        term_abs;
  logic               reject;
  logic signed [15:0] acc_next;
  logic signed [15:0] term_next;
  logic signed [15:0] pow_next;

  // Q8.8 multiply: full 32-bit signed product, arithmetic shift keeps floor rounding
  function automatic logic signed [15:0] qmul(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    return 16'(p >>> 8);
  endfunction

  function automatic logic signed [15:0] recip(input logic [3:0] idx);
    case (idx)
      4'd1:    return 16'sh0100;
      4'd2:    return 16'sh0080;
      4'd3:    return 16'sh0055;
      4'd4:    return 16'sh0040;
      4'd5:    return 16'sh0033;
      4'd6:    return 16'sh002B;
      4'd7:    return 16'sh0025;
      4'd8:    return 16'sh0020;
      default: return 16'sh0000;
    endcase
  endfunction

  always_comb begin
    in_range  = (x_reg >= 16'h0080) && (x_reg <= 16'h0180);
    term_abs  = term[15] ? 16'(-term) : term;
    reject    = term_abs <= {8'h00, eps_reg};
    acc_next  = k[0] ? (acc + term) : (acc - term);
    term_next = qmul(pow, recip(k));
    pow_next  = qmul(pow, u);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_reg     <= '0;
      eps_reg   <= '0;
      u         <= '0;
      pow       <= '0;
      acc       <= '0;
      term      <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      range_err <= 1'b0;
      terms     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_reg     <= x;
            eps_reg   <= eps;
            result    <= '0;
            terms     <= '0;
            range_err <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (!in_range) begin
            range_err <= 1'b1;
            result    <= '0;
            terms     <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            u     <= x_reg - 16'h0100;
            pow   <= x_reg - 16'h0100;
            acc   <= '0;
            k     <= 4'd1;
            state <= TERM;
          end
        end
        TERM: begin
          term  <= term_next;
          state <= ACC;
        end
        ACC: begin
          // A small term ends the series without contributing to the sum
          if (reject) begin
            result <= acc;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc   <= acc_next;
            pow   <= pow_next;
            terms <= terms + 4'd1;
            k     <= k + 4'd1;
            if (k == 4'(MAX_TERMS)) begin
              result <= acc_next;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= TERM;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ln_series.sv
// Directed-vector bench for ln_series: a default instance plus a MAX_TERMS=2
// instance with its own start line.
module tb_ln_series;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start2;
  logic [15:0] x;
  logic [7:0]  eps;

  logic        busy, done, range_err;
  logic [15:0] result;
  logic [3:0]  terms;
  logic        busy2, done2, range_err2;
  logic [15:0] result2;
  logic [3:0]  terms2;

  int checks = 0;
  int failures = 0;

  int          lat, pulses, lat2, pulses2;
  logic [15:0] cap_result, cap_result2;
  logic [3:0]  cap_terms, cap_terms2;
  logic        cap_rerr, cap_rerr2;

  ln_series u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .eps(eps),
    .busy(busy), .done(done), .result(result), .range_err(range_err), .terms(terms)
  );

  ln_series #(.MAX_TERMS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .x(x), .eps(eps),
    .busy(busy2), .done(done2), .result(result2), .range_err(range_err2), .terms(terms2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  eps;
    logic [15:0] exp_result;
    logic [3:0]  exp_terms;
    logic        exp_rerr;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Edge 0 is the accepting edge; outputs are sampled 1 time unit after each edge.
  // mode 1 re-pulses start mid-run, mode 2 pulses start in the DONE cycle.
  task automatic applyStimulus(input logic [15:0] xi, input logic [7:0] ei,
                               input bit use2, input int mode);
    lat = -1; pulses = 0; lat2 = -1; pulses2 = 0;
    @(negedge clk);
    x = xi; eps = ei; start = 1'b1; start2 = use2;
    @(posedge clk);
    #1 start = 1'b0; start2 = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = e; cap_result = result; cap_terms = terms; cap_rerr = range_err;
        end
      end
      if (done2) begin
        pulses2++;
        if (lat2 < 0) begin
          lat2 = e; cap_result2 = result2; cap_terms2 = terms2; cap_rerr2 = range_err2;
        end
      end
      if (mode == 1 && e == 3) begin
        start = 1'b1; x = 16'h0080; eps = 8'h00;
      end
      if (mode == 1 && e == 4) begin
        start = 1'b0; x = xi; eps = ei;
      end
      if (mode == 2 && lat == e) start = 1'b1;
      if (mode == 2 && lat >= 0 && e == lat + 1) begin
        start = 1'b0;
        check("done_cycle_start_ignored.busy", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic checkOutput(input string nm, input logic [15:0] r, input logic [3:0] t,
                             input logic re, input int l);
    check({nm, ".result"}, 32'(cap_result), 32'(r));
    check({nm, ".terms"}, 32'(cap_terms), 32'(t));
    check({nm, ".range_err"}, 32'(cap_rerr), 32'(re));
    check({nm, ".latency"}, 32'(lat), 32'(l));
    check({nm, ".pulses"}, 32'(pulses), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'h0100, 8'h00, 16'h0000, 4'd0, 1'b0, 3};
    vecs[1] = '{16'h0180, 8'h00, 16'h0067, 4'd5, 1'b0, 13};
    vecs[2] = '{16'h0180, 8'h04, 16'h006A, 4'd3, 1'b0, 9};
    vecs[3] = '{16'h0080, 8'h00, 16'hFF4F, 4'd5, 1'b0, 13};
    vecs[4] = '{16'h0200, 8'h00, 16'h0000, 4'd0, 1'b1, 1};
    vecs[5] = '{16'h007F, 8'h00, 16'h0000, 4'd0, 1'b1, 1};
    vecs[6] = '{16'h00C0, 8'h00, 16'hFFB6, 4'd3, 1'b0, 9};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; x = '0; eps = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.range_err", 32'(range_err), 32'd0);
    check("reset.terms", 32'(terms), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].x, vecs[i].eps, 1'b0, 0);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_terms,
                  vecs[i].exp_rerr, vecs[i].exp_lat);
    end

    // MAX_TERMS=2 stops after two accepted terms
    applyStimulus(16'h0180, 8'h00, 1'b1, 0);
    check("max2_pos.result", 32'(cap_result2), 32'h0060);
    check("max2_pos.terms", 32'(cap_terms2), 32'd2);
    check("max2_pos.latency", 32'(lat2), 32'd5);
    check("max2_pos.pulses", 32'(pulses2), 32'd1);
    applyStimulus(16'h0080, 8'h00, 1'b1, 0);
    check("max2_neg.result", 32'(cap_result2), 32'hFF60);
    check("max2_neg.terms", 32'(cap_terms2), 32'd2);

    applyStimulus(16'h0180, 8'h00, 1'b0, 1);
    checkOutput("repulse_busy", 16'h0067, 4'd5, 1'b0, 13);
    applyStimulus(16'h0180, 8'h04, 1'b0, 2);
    checkOutput("done_cycle_start", 16'h006A, 4'd3, 1'b0, 9);

    // Abort mid-run with reset after a second start while busy
    @(negedge clk);
    x = 16'h0180; eps = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) begin start = 1'b1; x = 16'h0080; end
    @(negedge clk) start = 1'b0;
    check("abort.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.terms", 32'(terms), 32'd0);
    check("abort.range_err", 32'(range_err), 32'd0);
    pulses = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    check("abort.no_activity", 32'(pulses), 32'd0);
    applyStimulus(16'h00C0, 8'h00, 1'b0, 0);
    checkOutput("after_abort", 16'hFFB6, 4'd3, 1'b0, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
